// File: rtl/pulse_gen.sv
// pulse_gen: free-running periodic pulse source with programmable width and period
module pulse_gen #(
  parameter int PULSE_WIDTH_WIDTH  = 8,
  parameter int PULSE_PERIOD_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PULSE_WIDTH_WIDTH-1:0]  pulse_width,
  input  logic [PULSE_PERIOD_WIDTH-1:0] pulse_period,
  output logic                          dout,
  output logic [PULSE_PERIOD_WIDTH-1:0] cnt
);
  logic [PULSE_PERIOD_WIDTH-1:0] cnt_next;
  logic [PULSE_PERIOD_WIDTH-1:0] period_m1;
  logic [PULSE_PERIOD_WIDTH-1:0] width_ext;
  logic                          wrap;
  // period 0 would underflow period_m1, so periods 0 and 1 both pin the count at 0
  always_comb begin
    period_m1 = pulse_period - PULSE_PERIOD_WIDTH'(1);
    width_ext = PULSE_PERIOD_WIDTH'(pulse_width);
    wrap      = (pulse_period <= PULSE_PERIOD_WIDTH'(1)) || (cnt >= period_m1);
    cnt_next  = wrap ? '0 : cnt + PULSE_PERIOD_WIDTH'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      dout <= cnt_next < width_ext;
    end
  end
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: scoreboard bench for pulse_gen against a behavioural period/duty model
module tb_pulse_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pulse_width;
  logic [15:0] pulse_period;
  logic        dout;
  logic [15:0] cnt;

  typedef struct {
    int c;
    bit d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;

  pulse_gen #(.PULSE_WIDTH_WIDTH(8), .PULSE_PERIOD_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .pulse_width(pulse_width),
    .pulse_period(pulse_period),
    .dout(dout),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: inputs change at negedge; the model predicts the next posedge
  task automatic step(input int w, input int p, input bit r);
    exp_t e;
    @(negedge clk);
    pulse_width  = w[7:0];
    pulse_period = p[15:0];
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      check("async_rst_cnt", int'(cnt), 0);
      check("async_rst_dout", int'(dout), 0);
    end
    rst = r;
    if (r) begin
      m_cnt = 0;
      e.d = 1'b0;
    end else begin
      m_cnt = (m_cnt + 1 < int'(pulse_period)) ? m_cnt + 1 : 0;
      e.d = m_cnt < int'(pulse_width);
    end
    e.c = m_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cnt", int'(cnt), e.c);
        check("dout", int'(dout), int'(e.d));
      end
    end
  end

  initial begin
    int w, p;
    rst = 1'b1;
    pulse_width = 8'd10;
    pulse_period = 16'd100;
    #3;
    check("reset_cnt", int'(cnt), 0);
    check("reset_dout", int'(dout), 0);
    repeat (2) step(10, 100, 1'b1);
    repeat (250) step(10, 100, 1'b0);
    while (m_cnt != 64) step(10, 100, 1'b0);
    step(10, 100, 1'b0);
    step(10, 100, 1'b1);
    repeat (30) step(10, 100, 1'b0);
    while (m_cnt != 70) step(10, 100, 1'b0);
    repeat (120) step(25, 50, 1'b0);
    repeat (60) step(0, 20, 1'b0);
    repeat (220) step(200, 100, 1'b0);
    repeat (10) step(5, 1, 1'b0);
    repeat (10) step(0, 0, 1'b0);
    repeat (10) step(3, 0, 1'b0);
    repeat (10) step(0, 1, 1'b0);
    w = 7;
    p = 20;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) w = $urandom_range(0, 50);
      if ($urandom_range(0, 29) == 0) p = $urandom_range(0, 45);
      step(w, p, $urandom_range(0, 99) == 0);
    end
    repeat (300) step(255, 65535, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
